audio_out_stage: RTL and testbench

Downstream consumer of the sample ROM player: accepts stereo 24-bit samples through a valid/ready handshake and buffers them in a small FIFO. It applies a volume attenuation and mute, then feeds the audio codec's write port one sample per `write_ready` slot. It starts playback only after a priming threshold of samples is buffered. It counts underruns, and on an underrun it substitutes silence instead of stalling the codec.

---
 rtl/audio_out_stage.sv | 109 ++++++++++
 tb/tb_audio_out_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_stage.sv
// Output stage that buffers stereo samples and feeds the codec write port.
// It primes the buffer before playback, then attenuates/mutes the samples and substitutes silence on underrun.
module audio_out_stage #(
   parameter int DEPTH = 8,
   parameter int PRIME = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [23:0]              in_left,
   input  logic [23:0]              in_right,
   output logic                     in_ready,
   input  logic [2:0]               volume,
   input  logic                     mute,
   input  logic                     write_ready,
   output logic                     write,
   output logic [23:0]              writedata_left,
   output logic [23:0]              writedata_right,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [15:0]              underruns
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;

   typedef enum logic {FILL, RUN} state_t;

   state_t          state, next_state;
   logic [23:0]     mem_left  [DEPTH];
   logic [23:0]     mem_right [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop, underrun;

   function automatic logic [23:0] scale(input logic [23:0] s, input logic [2:0] sh,
                                         input logic mu);
      logic signed [23:0] v;
      v = $signed(s) >>> sh;
      return mu ? 24'd0 : v;
   endfunction

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready = (fill != FW'(DEPTH));
   assign push     = in_valid & in_ready;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      underrun   = 1'b0;
      case (state)
         FILL: if (fill >= FW'(PRIME)) next_state = RUN;
         RUN: begin
            if (write_ready) begin
               if (fill != '0) begin
                  pop = 1'b1;
               end else begin
                  underrun   = 1'b1;
                  next_state = FILL;
               end
            end
         end
         default: next_state = FILL;
      endcase
   end

   // NOTE: the sample storage has no reset; fill and the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_left[wr_ptr]  <= in_left;
         mem_right[wr_ptr] <= in_right;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= FILL;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fill            <= '0;
         write           <= 1'b0;
         writedata_left  <= '0;
         writedata_right <= '0;
         underruns       <= '0;
      end else begin
         state <= next_state;
         write <= pop | underrun;
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
         if (pop) begin
            writedata_left  <= scale(mem_left[rd_ptr], volume, mute);
            writedata_right <= scale(mem_right[rd_ptr], volume, mute);
         end else if (underrun) begin
            writedata_left  <= '0;
            writedata_right <= '0;
            if (underruns != 16'hFFFF) underruns <= underruns + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_audio_out_stage.sv
// Self-checking bench for audio_out_stage: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_audio_out_stage;

   localparam int DEPTH = 8;
   localparam int PRIME = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [23:0] in_left, in_right;
   logic        in_ready;
   logic [2:0]  volume;
   logic        mute;
   logic        write_ready;
   logic        write;
   logic [23:0] writedata_left, writedata_right;
   logic [3:0]  fill;
   logic [15:0] underruns;

   always #5 clk = ~clk;

   audio_out_stage #(.DEPTH(DEPTH), .PRIME(PRIME)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_left(in_left),
      .in_right(in_right), .in_ready(in_ready), .volume(volume), .mute(mute),
      .write_ready(write_ready), .write(write), .writedata_left(writedata_left),
      .writedata_right(writedata_right), .fill(fill), .underruns(underruns)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: queue of {left,right}, a "playing" flag, and expected outputs.
   logic [47:0] q[$];
   bit          playing;
   int          m_under;
   bit          m_write;
   logic [23:0] m_left, m_right;

   function automatic logic [23:0] model_scale(input logic [23:0] s, input int sh, input bit mu);
      longint x, d, r;
      if (mu) return 24'd0;
      x = longint'($signed(s));
      d = longint'(1) << sh;
      r = (x >= 0) ? x / d : -((-x + d - 1) / d);   // floor division
      return r[23:0];
   endfunction

   task automatic model_reset();
      q.delete();
      playing = 0;
      m_under = 0;
      m_write = 0;
      m_left  = '0;
      m_right = '0;
   endtask

   task automatic drive(input bit v, input logic [23:0] l, input logic [23:0] r,
                        input bit wr, input int vol, input bit mu);
      in_valid    = v;
      in_left     = l;
      in_right    = r;
      write_ready = wr;
      volume      = vol[2:0];
      mute        = mu;
   endtask

   // One clock: predict from pre-edge inputs, advance, then compare everything.
   task automatic step();
      bit          accept;
      logic [47:0] s;
      check("in_ready", in_ready, (q.size() != DEPTH));
      accept  = in_valid && (q.size() != DEPTH);
      m_write = 0;
      if (playing) begin
         if (write_ready) begin
            m_write = 1;
            if (q.size() > 0) begin
               s       = q.pop_front();
               m_left  = model_scale(s[47:24], int'(volume), mute);
               m_right = model_scale(s[23:0], int'(volume), mute);
            end else begin
               m_left  = '0;
               m_right = '0;
               if (m_under < 65535) m_under++;
               playing = 0;
            end
         end
      end else if (q.size() >= PRIME) begin
         playing = 1;
      end
      if (accept) q.push_back({in_left, in_right});
      @(posedge clk);
      #1;
      check("write", write, m_write);
      check("wd_left", writedata_left, m_left);
      check("wd_right", writedata_right, m_right);
      check("fill", fill, q.size());
      check("underruns", underruns, m_under);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, '0, '0, 0, 0, 0);
      model_reset();
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_write", write, 0);
      check("rst_wd_left", writedata_left, 0);
      check("rst_wd_right", writedata_right, 0);
      check("rst_fill", fill, 0);
      check("rst_underruns", underruns, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Prime: three samples are not enough to start playback.
      for (int i = 1; i <= 3; i++) begin
         drive(1, 24'(i * 256), 24'(i * 16), 1, 0, 0);
         step();
      end
      check("prime_fill3", fill, 3);
      drive(1, 24'h000400, 24'h000040, 1, 0, 0);
      step();
      // Drain four samples in order, then one silent underrun, then idle.
      drive(0, '0, '0, 1, 0, 0);
      step();
      step();
      check("first_out", writedata_left, 24'h000100);
      for (int i = 0; i < 6; i++) step();
      check("underrun_count", underruns, 1);
      check("idle_no_write", write, 0);

      // Full backpressure.
      for (int i = 0; i < 10; i++) begin
         drive(1, $urandom(), $urandom(), 0, 0, 0);
         step();
      end
      check("full_fill", fill, 8);
      check("full_in_ready", in_ready, 0);
      drive(1, 24'h0ABCDE, 24'h012345, 1, 0, 0);
      step();
      check("after_pop_fill", fill, 7);
      check("after_pop_in_ready", in_ready, 1);
      drive(0, '0, '0, 1, 0, 0);
      for (int i = 0; i < 9; i++) step();

      // Scaling and mute.
      drive(1, 24'h7FFFF0, 24'h7FFFF0, 0, 0, 0); step();
      drive(1, 24'h800000, 24'h800000, 0, 0, 0); step();
      drive(1, 24'h123456, 24'h654321, 0, 0, 0); step();
      drive(1, 24'hF00001, 24'h000007, 0, 0, 0); step();
      drive(0, '0, '0, 0, 0, 0);                 step();
      drive(0, '0, '0, 1, 4, 0);                 step();
      check("scale_pos", writedata_left, 24'h07FFFF);
      drive(0, '0, '0, 1, 1, 0);                 step();
      check("scale_neg", writedata_left, 24'hC00000);
      drive(0, '0, '0, 1, 3, 1);                 step();
      check("mute", writedata_left, 24'h000000);
      drive(0, '0, '0, 1, 2, 0);
      for (int i = 0; i < 3; i++) step();

      // Simultaneous push/pop at fill 5 across pointer wraps.
      for (int i = 0; i < 5; i++) begin
         drive(1, $urandom(), $urandom(), 0, 0, 0);
         step();
      end
      for (int i = 0; i < 16; i++) begin
         drive(1, $urandom(), $urandom(), 1, $urandom_range(0, 7), 0);
         step();
         check("pushpop_fill5", fill, 5);
      end

      // Asynchronous reset between edges with fill = 6.
      drive(1, 24'h00AAAA, 24'h00BBBB, 0, 0, 0);
      step();
      check("pre_reset_fill", fill, 6);
      drive(0, '0, '0, 0, 0, 0);
      #3;
      reset = 1'b1;
      #1;
      check("async_fill", fill, 0);
      check("async_write", write, 0);
      check("async_underruns", underruns, 0);
      check("async_in_ready", in_ready, 1);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom(), $urandom(),
               $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 7) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
